instruction_loader: RTL and testbench
=====================================

// Module: instruction_loader
// PURPOSE
//  Write-side front end for the instruction memory: accepts a byte stream over a
//  valid/ready handshake and packs each 4 bytes big-endian into a 32-bit word.
//  Writes words to consecutive addresses from 0 through the memory's WE/ADDRESS/DATA port.
//  Holds the CPU (CPU_HOLD) while a program image is loaded; signals DONE at the end.
// PARAMETERS
//  ADDR_W  10    instruction memory address width
//  DEPTH   1024  instruction memory words; must equal 2**ADDR_W
// PORTS
//  CLK       in   1       single clock, rising edge
//  RESET     in   1       synchronous, active-high reset
//  START     in   1       one-cycle pulse; starts a load (sampled only in IDLE/DONE)
//  LEN       in   ADDR_W+1  words to load, sampled on accepted START
//  IN_VALID  in   1       byte source has a byte on IN_DATA
//  IN_DATA   in   8       stream byte
//  IN_READY  out  1       loader accepts IN_DATA this cycle
//  WE        out  1       instruction memory write enable
//  ADDRESS   out  ADDR_W  instruction memory word address
//  DATA      out  32      instruction memory write data
//  BUSY      out  1       load in progress
//  DONE      out  1       load finished; held until next START or RESET
//  CPU_HOLD  out  1       keep processor stalled/reset while high
// BEHAVIOUR
//  - Reset (sync, wins over all inputs): state=IDLE; WE=0, IN_READY=0, BUSY=0, DONE=0,
//    CPU_HOLD=0, ADDRESS=0, DATA=0; byte_cnt=0, word_cnt=0; any partial word discarded.
//  - States: IDLE, COLLECT, WRITE, FINISH.
//  - IDLE/FINISH + START: len_q = min(LEN, DEPTH); word_cnt=0; byte_cnt=0; DONE=0.
//    Then len_q==0 -> FINISH (DONE=1 next cycle, no writes); else -> COLLECT.
//  - START in COLLECT/WRITE: ignored.
//  - COLLECT: IN_READY=1. A byte is accepted when IN_VALID&&IN_READY.
//    First accepted byte -> DATA[31:24], then [23:16], [15:8], [7:0].
//    byte_cnt increments mod 4. On the 4th byte -> WRITE.
//    No IN_VALID: stay in COLLECT, no timeout.
//  - WRITE: exactly one cycle. WE=1, ADDRESS=word_cnt, DATA=assembled word, IN_READY=0.
//    If word_cnt==len_q-1 -> FINISH; else word_cnt++ -> COLLECT.
//  - Latency: WE high the cycle after the 4th byte is accepted.
//    Peak rate is 1 word per 5 cycles.
//  - FINISH: DONE=1, BUSY=0, CPU_HOLD=0, WE=0, IN_READY=0.
//  - BUSY = CPU_HOLD = (state==COLLECT || state==WRITE).
//  - WE is 0 in every state except WRITE. ADDRESS and DATA keep their last values
//    outside WRITE.
//  - Wrap-around: word_cnt never exceeds DEPTH-1 because len_q is clamped.
//    LEN>DEPTH loads DEPTH words.
//  - RESET mid-load: returns to IDLE immediately. Memory keeps words already written.
//  - Bytes offered while not in COLLECT are not accepted (IN_READY=0). The source must hold them.
// STRUCTURE
//  - Shared package: state encoding (IDLE=0, COLLECT=1, WRITE=2, FINISH=3) and BYTES_PER_WORD=4.
//  - Sub-module word_packer: byte shift register + byte_cnt.
//    Outputs word_full and word[31:0]; clear input driven on START/RESET.
//  - Top level: FSM, word_cnt/len_q registers, output decode.
// TESTING
//  1. RESET held 2 cycles with IN_VALID=1 and START=1 -> all outputs 0, state IDLE.
//  2. START, LEN=2, bytes 01 23 45 67 89 AB CD EF (IN_VALID always 1)
//     -> WE at addr 0 with 0x01234567, then addr 1 with 0x89ABCDEF. DONE=1 after; CPU_HOLD low.
//  3. LEN=1 with IN_VALID toggled every other cycle -> single write of the correct word.
//     IN_READY=0 during WRITE; no byte dropped or duplicated.
//  4. LEN=0 -> DONE=1 two cycles after START, WE never asserted, IN_READY never asserted.
//  5. LEN=1500 -> exactly 1024 writes, last at ADDRESS=1023, then DONE; no write at address 0 twice.
//  6. RESET after 2 bytes of word 3 -> IDLE, no WE.
//     New START with LEN=1 -> first 4 new bytes written to addr 0; stale bytes absent.

Source files
------------

// File: rtl/instruction_loader_pkg.sv
// instruction_loader_pkg: shared state encoding and word geometry for the instruction loader.
package instruction_loader_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        FINISH  = 2'd3
    } state_t;
    localparam int BYTES_PER_WORD = 4;
endpackage

// File: rtl/instruction_loader_word_packer.sv
// instruction_loader_word_packer: shifts accepted bytes into a big-endian 32-bit word.
module instruction_loader_word_packer
    import instruction_loader_pkg::*;
(
    input  logic        clk,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  byte_in,
    output logic        word_full,
    output logic [31:0] word
);
    logic [23:0] shift_q, shift_d;
    logic [1:0]  cnt_q, cnt_d;
    // word includes the byte being accepted now, so it is complete on the 4th accept
    always_comb begin
        word      = {shift_q, byte_in};
        word_full = accept && (cnt_q == 2'(BYTES_PER_WORD - 1));
        shift_d   = clear ? 24'd0 : accept ? word[23:0] : shift_q;
        cnt_d     = clear ? 2'd0 : accept ? cnt_q + 2'd1 : cnt_q;
    end
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
        cnt_q   <= cnt_d;
    end
endmodule

// File: rtl/instruction_loader.sv
// instruction_loader: packs a byte stream into 32-bit words and writes them to
// instruction memory from address 0, holding the CPU while the image loads.
module instruction_loader
    import instruction_loader_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    input  logic [ADDR_W:0]   LEN,
    input  logic              IN_VALID,
    input  logic [7:0]        IN_DATA,
    output logic              IN_READY,
    output logic              WE,
    output logic [ADDR_W-1:0] ADDRESS,
    output logic [31:0]       DATA,
    output logic              BUSY,
    output logic              DONE,
    output logic              CPU_HOLD
);
    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);

    state_t            state_q, state_d;
    logic [ADDR_W:0]   len_q, len_d, len_in;
    logic [ADDR_W-1:0] word_cnt_q, word_cnt_d, addr_q, addr_d;
    logic [31:0]       data_q, data_d, word;
    logic              start_acc, accept, word_full, last;

    instruction_loader_word_packer u_packer (
        .clk       (CLK),
        .clear     (RESET || start_acc),
        .accept    (accept),
        .byte_in   (IN_DATA),
        .word_full (word_full),
        .word      (word)
    );

    always_comb begin
        start_acc  = START && (state_q == IDLE || state_q == FINISH);
        accept     = IN_VALID && (state_q == COLLECT);
        len_in     = (LEN > DEPTH_W) ? DEPTH_W : LEN;
        last       = ({1'b0, word_cnt_q} == len_q - 1'b1);
        state_d    = state_q;
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        addr_d     = addr_q;
        data_d     = data_q;
        if (start_acc) begin
            len_d      = len_in;
            word_cnt_d = '0;
            state_d    = (len_in == '0) ? FINISH : COLLECT;
        end else if (state_q == COLLECT && word_full) begin
            state_d = WRITE;
            addr_d  = word_cnt_q;
            data_d  = word;
        end else if (state_q == WRITE) begin
            state_d    = last ? FINISH : COLLECT;
            word_cnt_d = last ? word_cnt_q : word_cnt_q + 1'b1;
        end
        IN_READY = (state_q == COLLECT);
        WE       = (state_q == WRITE);
        BUSY     = (state_q == COLLECT) || (state_q == WRITE);
        CPU_HOLD = BUSY;
        DONE     = (state_q == FINISH);
        ADDRESS  = addr_q;
        DATA     = data_q;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= IDLE;
            len_q      <= '0;
            word_cnt_q <= '0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_cnt_q <= word_cnt_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
        end
    end
endmodule

// File: tb/tb_instruction_loader.sv
// tb_instruction_loader: random byte streams checked against a queue-based model of the loaded image.
module tb_instruction_loader;
    logic        CLK = 0;
    logic        RESET, START, IN_VALID;
    logic [10:0] LEN;
    logic [7:0]  IN_DATA;
    logic        IN_READY, WE, BUSY, DONE, CPU_HOLD;
    logic [9:0]  ADDRESS;
    logic [31:0] DATA;

    typedef struct { int addr; logic [31:0] data; } wr_t;
    wr_t        wlog[$];
    logic [7:0] sent[$];
    int checks = 0, failures = 0, ready_cnt = 0, overlap = 0;

    instruction_loader dut (
        .CLK(CLK), .RESET(RESET), .START(START), .LEN(LEN),
        .IN_VALID(IN_VALID), .IN_DATA(IN_DATA), .IN_READY(IN_READY),
        .WE(WE), .ADDRESS(ADDRESS), .DATA(DATA),
        .BUSY(BUSY), .DONE(DONE), .CPU_HOLD(CPU_HOLD)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (WE) wlog.push_back('{int'(ADDRESS), DATA});
        if (IN_READY) ready_cnt++;
        if (WE && IN_READY) overlap++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_load(input int len);
        @(negedge CLK);
        START = 1;
        LEN = 11'(len);
        @(negedge CLK);
        START = 0;
    endtask

    task automatic feed(input int n, input bit toggle);
        for (int i = 0; i < n; i++) begin
            logic [7:0] b;
            bit acc;
            int guard;
            b = 8'($urandom);
            sent.push_back(b);
            acc = 0;
            guard = 0;
            while (!acc && guard < 50) begin
                @(negedge CLK);
                IN_VALID = toggle ? 1'($urandom) : 1'b1;
                IN_DATA = b;
                acc = IN_VALID && IN_READY;
                guard++;
            end
            if (!acc) check("feed_timeout", 0, 1);
        end
        @(negedge CLK);
        IN_VALID = 0;
        IN_DATA = 8'($urandom);
    endtask

    task automatic wait_done();
        int guard = 0;
        while (!DONE && guard < 20) begin
            @(negedge CLK);
            guard++;
        end
        check("done", DONE, 1);
    endtask

    // expected image: words formed big-endian from sent bytes at addresses 0..min(len,1024)-1
    task automatic check_image(input string tag, input int len, input bit per_word);
        int n = (len > 1024) ? 1024 : len;
        int bad = 0;
        check({tag, "_count"}, wlog.size(), n);
        for (int k = 0; k < n && k < wlog.size(); k++) begin
            logic [31:0] exp = {sent[4*k], sent[4*k+1], sent[4*k+2], sent[4*k+3]};
            if (per_word) begin
                check({tag, "_addr"}, wlog[k].addr, k);
                check({tag, "_data"}, wlog[k].data, exp);
            end else if (wlog[k].addr != k || wlog[k].data !== exp) bad++;
        end
        if (!per_word) check({tag, "_bad_words"}, bad, 0);
    endtask

    initial begin
        RESET = 1; START = 1; IN_VALID = 1; IN_DATA = 8'hFF; LEN = 11'd5;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_outs", {WE, IN_READY, BUSY, DONE, CPU_HOLD}, 0);
        check("rst_addr", ADDRESS, 0);
        check("rst_data", DATA, 0);
        RESET = 0; START = 0; IN_VALID = 0;

        wlog.delete(); sent.delete();
        start_load(2);
        check("busy_hold", {BUSY, CPU_HOLD}, 2'b11);
        feed(8, 0);
        wait_done();
        check_image("len2", 2, 1);
        check("len2_hold", {BUSY, CPU_HOLD}, 0);

        wlog.delete(); sent.delete(); overlap = 0;
        start_load(1);
        feed(4, 1);
        wait_done();
        check_image("len1", 1, 1);
        check("ready_in_write", overlap, 0);

        wlog.delete(); sent.delete(); ready_cnt = 0;
        start_load(0);
        @(negedge CLK);
        check("len0_done", DONE, 1);
        repeat (3) @(negedge CLK);
        check("len0_writes", wlog.size(), 0);
        check("len0_ready", ready_cnt, 0);

        wlog.delete(); sent.delete(); overlap = 0;
        start_load(1500);
        feed(4096, 0);
        wait_done();
        check_image("len1500", 1500, 0);
        if (wlog.size() > 0) check("len1500_last", wlog[wlog.size()-1].addr, 1023);
        check("len1500_overlap", overlap, 0);

        wlog.delete(); sent.delete();
        start_load(4);
        feed(10, 1);
        repeat (2) @(negedge CLK);
        RESET = 1;
        @(negedge CLK);
        RESET = 0;
        check("midrst_writes", wlog.size(), 2);
        check("midrst_outs", {WE, IN_READY, BUSY, DONE, CPU_HOLD}, 0);
        repeat (3) @(negedge CLK);
        check("midrst_quiet", wlog.size(), 2);
        wlog.delete(); sent.delete();
        start_load(1);
        feed(4, 0);
        wait_done();
        check_image("after_rst", 1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
